// File: rtl/uart_cmd_decoder_pkg.sv
// Shared byte constants, state encodings and helpers for the UART command decoder
// and its response sender.
package uart_cmd_decoder_pkg;

    localparam logic [7:0] CMD_ON      = 8'h2A;
    localparam logic [7:0] CMD_OFF     = 8'h93;
    localparam logic [7:0] CMD_TOGGLE  = 8'hC3;
    localparam logic [7:0] CMD_SET_MOD = 8'h5A;
    localparam logic [7:0] RSP_ACK     = 8'h6B;
    localparam logic [7:0] RSP_NACK    = 8'hE1;

    // Last wait cycle (0-based) for uart_tx to raise busy after a launch
    localparam logic [1:0] TX_BUSY_WAIT_LAST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GET_ARG = 2'd1,
        ST_GET_CHK = 2'd2
    } parse_state_e;

    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_PEND    = 2'd1,
        SLOT_WAIT_HI = 2'd2,
        SLOT_WAIT_LO = 2'd3
    } slot_state_e;

    function automatic logic [7:0] set_mod_check(input logic [7:0] arg);
        return CMD_SET_MOD ^ arg;
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-level link between uart_rx/uart_tx (master side) and the command decoder (slave side).
interface uart_cmd_decoder_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       parity_error;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       start_tx;

    modport master (
        output rx_data, rx_done, parity_error, tx_busy,
        input  tx_data, start_tx
    );

    modport slave (
        input  rx_data, rx_done, parity_error, tx_busy,
        output tx_data, start_tx
    );
endinterface

// File: rtl/uart_cmd_decoder_resp_sender.sv
// One-entry response slot feeding uart_tx: launches a byte when tx is idle, then waits for
// the busy high/low cycle (or a short no-answer window) before accepting the next response.
module uart_cmd_decoder_resp_sender
    import uart_cmd_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_byte,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       start_tx,
    output logic       drop
);

    slot_state_e slot_q, slot_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [1:0]  wait_q, wait_d;
    logic        start_s;
    logic        drop_s;

    // Slot state, launch decision and overwrite/drop detection
    always_comb begin
        slot_d    = slot_q;
        tx_data_d = tx_data_q;
        wait_d    = wait_q;
        start_s   = 1'b0;
        drop_s    = 1'b0;
        case (slot_q)
            SLOT_EMPTY: begin
                if (push) begin
                    tx_data_d = push_byte;
                    slot_d    = SLOT_PEND;
                end
            end
            SLOT_PEND: begin
                // A byte launching this cycle is committed; a concurrent push loses
                if (!tx_busy) begin
                    start_s = 1'b1;
                    slot_d  = SLOT_WAIT_HI;
                    wait_d  = 2'd0;
                    drop_s  = push;
                end else if (push) begin
                    tx_data_d = push_byte;
                    drop_s    = 1'b1;
                end
            end
            SLOT_WAIT_HI: begin
                drop_s = push;
                if (tx_busy) begin
                    slot_d = SLOT_WAIT_LO;
                end else if (wait_q == TX_BUSY_WAIT_LAST) begin
                    slot_d = SLOT_EMPTY;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            SLOT_WAIT_LO: begin
                drop_s = push;
                if (!tx_busy) begin
                    slot_d = SLOT_EMPTY;
                end
            end
            default: begin
                slot_d = SLOT_EMPTY;
            end
        endcase
    end

    // Slot registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q    <= SLOT_EMPTY;
            tx_data_q <= 8'h00;
            wait_q    <= 2'd0;
        end else begin
            slot_q    <= slot_d;
            tx_data_q <= tx_data_d;
            wait_q    <= wait_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign start_tx = start_s;
    assign drop     = drop_s;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses 1-byte (ON/OFF/TOGGLE) and 3-byte (SET_MOD, arg, check) command frames from uart_rx,
// drives the SPWM control outputs and answers every complete frame with ACK or NACK.
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1200,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_cmd_decoder_if.slave    bus,
    output logic                 out_enable,
    output logic [7:0]           mod_index,
    output logic                 cmd_strobe,
    output logic [CNT_W-1:0]     err_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    parse_state_e     state_q, state_d;
    logic [7:0]       arg_q, arg_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             out_enable_q, out_enable_d;
    logic [7:0]       mod_index_q, mod_index_d;
    logic             cmd_strobe_q, cmd_strobe_d;
    logic             resp_push_q, resp_push_d;
    logic [7:0]       resp_byte_q, resp_byte_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W:0]   err_sum_s;
    logic             nack_s;
    logic             drop_s;
    logic             tmo_hit_s;

    assign tmo_hit_s = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Frame parser, inter-byte timeout and saturating error counter
    always_comb begin
        state_d      = state_q;
        arg_d        = arg_q;
        tmo_d        = tmo_q;
        out_enable_d = out_enable_q;
        mod_index_d  = mod_index_q;
        cmd_strobe_d = 1'b0;
        resp_push_d  = 1'b0;
        resp_byte_d  = resp_byte_q;
        nack_s       = 1'b0;
        err_sum_s    = {(CNT_W+1){1'b0}};
        err_count_d  = err_count_q;
        case (state_q)
            ST_IDLE: begin
                tmo_d = {TMO_W{1'b0}};
                if (bus.rx_done) begin
                    if (bus.parity_error) begin
                        nack_s = 1'b1;
                    end else begin
                        case (bus.rx_data)
                            CMD_ON: begin
                                out_enable_d = 1'b1;
                                cmd_strobe_d = 1'b1;
                            end
                            CMD_OFF: begin
                                out_enable_d = 1'b0;
                                cmd_strobe_d = 1'b1;
                            end
                            CMD_TOGGLE: begin
                                out_enable_d = ~out_enable_q;
                                cmd_strobe_d = 1'b1;
                            end
                            CMD_SET_MOD: begin
                                state_d = ST_GET_ARG;
                            end
                            default: begin
                                nack_s = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_GET_ARG: begin
                if (bus.rx_done) begin
                    tmo_d = {TMO_W{1'b0}};
                    if (bus.parity_error) begin
                        nack_s  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        arg_d   = bus.rx_data;
                        state_d = ST_GET_CHK;
                    end
                end else if (tmo_hit_s) begin
                    nack_s  = 1'b1;
                    state_d = ST_IDLE;
                    tmo_d   = {TMO_W{1'b0}};
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_GET_CHK: begin
                if (bus.rx_done) begin
                    tmo_d   = {TMO_W{1'b0}};
                    state_d = ST_IDLE;
                    if (!bus.parity_error && (bus.rx_data == set_mod_check(arg_q))) begin
                        mod_index_d  = arg_q;
                        cmd_strobe_d = 1'b1;
                    end else begin
                        nack_s = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    nack_s  = 1'b1;
                    state_d = ST_IDLE;
                    tmo_d   = {TMO_W{1'b0}};
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmo_d   = {TMO_W{1'b0}};
            end
        endcase

        // Every applied command is ACKed; everything else that completes a frame is NACKed
        if (cmd_strobe_d) begin
            resp_push_d = 1'b1;
            resp_byte_d = RSP_ACK;
        end else if (nack_s) begin
            resp_push_d = 1'b1;
            resp_byte_d = RSP_NACK;
        end else begin
            resp_push_d = 1'b0;
        end

        err_sum_s = {1'b0, err_count_q} + {{CNT_W{1'b0}}, nack_s} + {{CNT_W{1'b0}}, drop_s};
        if (err_sum_s[CNT_W]) begin
            err_count_d = {CNT_W{1'b1}};
        end else begin
            err_count_d = err_sum_s[CNT_W-1:0];
        end
    end

    // Parser and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            arg_q        <= 8'h00;
            tmo_q        <= {TMO_W{1'b0}};
            out_enable_q <= 1'b0;
            mod_index_q  <= 8'h00;
            cmd_strobe_q <= 1'b0;
            resp_push_q  <= 1'b0;
            resp_byte_q  <= 8'h00;
            err_count_q  <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            arg_q        <= arg_d;
            tmo_q        <= tmo_d;
            out_enable_q <= out_enable_d;
            mod_index_q  <= mod_index_d;
            cmd_strobe_q <= cmd_strobe_d;
            resp_push_q  <= resp_push_d;
            resp_byte_q  <= resp_byte_d;
            err_count_q  <= err_count_d;
        end
    end

    uart_cmd_decoder_resp_sender u_resp_sender (
        .clk       (clk),
        .reset     (reset),
        .push      (resp_push_q),
        .push_byte (resp_byte_q),
        .tx_busy   (bus.tx_busy),
        .tx_data   (bus.tx_data),
        .start_tx  (bus.start_tx),
        .drop      (drop_s)
    );

    assign out_enable = out_enable_q;
    assign mod_index  = mod_index_q;
    assign cmd_strobe = cmd_strobe_q;
    assign err_count  = err_count_q;

endmodule
